// File: rtl/demod_ctrl_pkg.sv
// Shared types and constants for the demodulation controller.
package demod_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCapture = 3'd1,
        StFftWait = 3'd2,
        StDemod   = 3'd3,
        StReport  = 3'd4
    } state_e;

    localparam logic [1:0] CLS_NONE = 2'd0;
    localparam logic [1:0] CLS_AM   = 2'd1;
    localparam logic [1:0] CLS_FM   = 2'd2;
    localparam logic [1:0] CLS_ASK  = 2'd3;

    localparam logic [2:0] DEMOD_EN_NONE = 3'b000;
    localparam logic [2:0] DEMOD_EN_AM   = 3'b001;
    localparam logic [2:0] DEMOD_EN_FM   = 3'b010;
    localparam logic [2:0] DEMOD_EN_ASK  = 3'b100;

    localparam int unsigned TIMER_W = 21;

    // Map a classifier result to the matching demodulator enable.
    function automatic logic [2:0] class_onehot(input logic [1:0] cls);
        logic [2:0] oh;
        case (cls)
            CLS_AM:  oh = DEMOD_EN_AM;
            CLS_FM:  oh = DEMOD_EN_FM;
            CLS_ASK: oh = DEMOD_EN_ASK;
            default: oh = DEMOD_EN_NONE;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demod_ctrl_if.sv
// Handshake bundle between the controller and its ADC/FFT/demod/report peers.
interface demod_ctrl_if #(
    parameter int unsigned AW = 12
);
    logic          en;
    logic          adc_valid;
    logic          cap_we;
    logic [AW-1:0] cap_addr;
    logic          fft_start;
    logic          fft_done;
    logic [1:0]    mod_class;
    logic [2:0]    demod_en;
    logic          dem_valid;
    logic [7:0]    dem_freq;
    logic [3:0]    dem_rate;
    logic          res_valid;
    logic [1:0]    res_type;
    logic [7:0]    res_freq;
    logic [3:0]    res_rate;
    logic          timeout_err;
    logic          busy;

    modport master (
        output en, adc_valid, fft_done, mod_class, dem_valid, dem_freq, dem_rate,
        input  cap_we, cap_addr, fft_start, demod_en, res_valid, res_type, res_freq,
               res_rate, timeout_err, busy
    );

    modport slave (
        input  en, adc_valid, fft_done, mod_class, dem_valid, dem_freq, dem_rate,
        output cap_we, cap_addr, fft_start, demod_en, res_valid, res_type, res_freq,
               res_rate, timeout_err, busy
    );
endinterface

// File: rtl/demod_ctrl_timer.sv
// DEMOD watchdog: counts cycles while enabled, flags the last allowed cycle.
module demod_timer
    import demod_pkg::*;
#(
    parameter int unsigned TIMEOUT = 2000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [TIMER_W-1:0] LastCnt = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    assign expired = en && (cnt_q == LastCnt);

    // Clear has priority; saturate at the last count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/demod_ctrl.sv
// Measurement round sequencer: capture -> FFT classify -> demodulate -> report.
module demod_ctrl
    import demod_pkg::*;
#(
    parameter int unsigned CAP_LEN = 1024,
    parameter int unsigned TIMEOUT = 2000000,
    parameter int unsigned AW      = 12
) (
    input  logic         clk,
    input  logic         rst,
    demod_ctrl_if.slave  bus
);
    localparam logic [AW-1:0] LastAddr = AW'(CAP_LEN - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cap_addr_q, cap_addr_d;
    logic          fft_start_q, fft_start_d;
    logic [1:0]    cls_q, cls_d;
    logic [1:0]    res_type_q, res_type_d;
    logic [7:0]    res_freq_q, res_freq_d;
    logic [3:0]    res_rate_q, res_rate_d;
    logic          timeout_err_q, timeout_err_d;
    logic          tmr_expired;

    // Counter is held at zero outside DEMOD so every entry starts fresh.
    demod_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q != StDemod),
        .en      (state_q == StDemod),
        .expired (tmr_expired)
    );

    // Next-state and result capture; result registers change only on REPORT entry.
    always_comb begin
        state_d       = state_q;
        cap_addr_d    = cap_addr_q;
        fft_start_d   = 1'b0;
        cls_d         = cls_q;
        res_type_d    = res_type_q;
        res_freq_d    = res_freq_q;
        res_rate_d    = res_rate_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            StIdle: begin
                if (bus.en) begin
                    state_d       = StCapture;
                    cap_addr_d    = '0;
                    timeout_err_d = 1'b0;
                end
            end
            StCapture: begin
                if (bus.adc_valid) begin
                    if (cap_addr_q == LastAddr) begin
                        // Park on the last address instead of wrapping.
                        state_d     = StFftWait;
                        fft_start_d = 1'b1;
                    end else begin
                        cap_addr_d = cap_addr_q + 1'b1;
                    end
                end
            end
            StFftWait: begin
                if (bus.fft_done) begin
                    cls_d = bus.mod_class;
                    if (bus.mod_class == CLS_NONE) begin
                        state_d    = StReport;
                        res_type_d = CLS_NONE;
                        res_freq_d = 8'd0;
                        res_rate_d = 4'd0;
                    end else begin
                        state_d = StDemod;
                    end
                end
            end
            StDemod: begin
                // A result on the expiry cycle still counts as a valid measurement.
                if (bus.dem_valid) begin
                    state_d    = StReport;
                    res_type_d = cls_q;
                    res_freq_d = bus.dem_freq;
                    res_rate_d = (cls_q == CLS_ASK) ? bus.dem_rate : 4'd0;
                end else if (tmr_expired) begin
                    state_d       = StReport;
                    res_type_d    = cls_q;
                    res_freq_d    = 8'd0;
                    res_rate_d    = 4'd0;
                    timeout_err_d = 1'b1;
                end
            end
            StReport: begin
                if (bus.en) begin
                    state_d    = StCapture;
                    cap_addr_d = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cap_addr_q    <= '0;
            fft_start_q   <= 1'b0;
            cls_q         <= CLS_NONE;
            res_type_q    <= CLS_NONE;
            res_freq_q    <= 8'd0;
            res_rate_q    <= 4'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cap_addr_q    <= cap_addr_d;
            fft_start_q   <= fft_start_d;
            cls_q         <= cls_d;
            res_type_q    <= res_type_d;
            res_freq_q    <= res_freq_d;
            res_rate_q    <= res_rate_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.cap_we      = (state_q == StCapture) && bus.adc_valid;
    assign bus.cap_addr    = cap_addr_q;
    assign bus.fft_start   = fft_start_q;
    assign bus.demod_en    = (state_q == StDemod) ? class_onehot(cls_q) : DEMOD_EN_NONE;
    assign bus.res_valid   = (state_q == StReport);
    assign bus.res_type    = res_type_q;
    assign bus.res_freq    = res_freq_q;
    assign bus.res_rate    = res_rate_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.busy        = (state_q != StIdle);
endmodule

// File: tb/tb_demod_ctrl.sv
// Directed bench for demod_ctrl: one instance with the default watchdog, one with a
// 100-cycle watchdog; sel picks which one the shared stimulus drives and observes.
module tb_demod_ctrl;
    import demod_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       sel;
    logic       en, adc_valid, fft_done, dem_valid;
    logic [1:0] mod_class;
    logic [7:0] dem_freq;
    logic [3:0] dem_rate;

    demod_ctrl_if #(.AW(12)) bus_n ();
    demod_ctrl_if #(.AW(12)) bus_t ();

    demod_ctrl #(.CAP_LEN(256), .TIMEOUT(2000000), .AW(12)) dut_n (
        .clk (clk),
        .rst (rst),
        .bus (bus_n)
    );

    demod_ctrl #(.CAP_LEN(256), .TIMEOUT(100), .AW(12)) dut_t (
        .clk (clk),
        .rst (rst),
        .bus (bus_t)
    );

    assign bus_n.en        = en & ~sel;
    assign bus_t.en        = en & sel;
    assign bus_n.adc_valid = adc_valid;
    assign bus_t.adc_valid = adc_valid;
    assign bus_n.fft_done  = fft_done;
    assign bus_t.fft_done  = fft_done;
    assign bus_n.mod_class = mod_class;
    assign bus_t.mod_class = mod_class;
    assign bus_n.dem_valid = dem_valid;
    assign bus_t.dem_valid = dem_valid;
    assign bus_n.dem_freq  = dem_freq;
    assign bus_t.dem_freq  = dem_freq;
    assign bus_n.dem_rate  = dem_rate;
    assign bus_t.dem_rate  = dem_rate;

    logic        o_cap_we, o_fft_start, o_res_valid, o_timeout_err, o_busy;
    logic [11:0] o_cap_addr;
    logic [2:0]  o_demod_en;
    logic [1:0]  o_res_type;
    logic [7:0]  o_res_freq;
    logic [3:0]  o_res_rate;
    logic [33:0] o_all;

    always_comb begin
        o_cap_we      = sel ? bus_t.cap_we      : bus_n.cap_we;
        o_cap_addr    = sel ? bus_t.cap_addr    : bus_n.cap_addr;
        o_fft_start   = sel ? bus_t.fft_start   : bus_n.fft_start;
        o_demod_en    = sel ? bus_t.demod_en    : bus_n.demod_en;
        o_res_valid   = sel ? bus_t.res_valid   : bus_n.res_valid;
        o_res_type    = sel ? bus_t.res_type    : bus_n.res_type;
        o_res_freq    = sel ? bus_t.res_freq    : bus_n.res_freq;
        o_res_rate    = sel ? bus_t.res_rate    : bus_n.res_rate;
        o_timeout_err = sel ? bus_t.timeout_err : bus_n.timeout_err;
        o_busy        = sel ? bus_t.busy        : bus_n.busy;
        o_all = {o_cap_we, o_cap_addr, o_fft_start, o_demod_en, o_res_valid, o_res_type,
                 o_res_freq, o_res_rate, o_timeout_err, o_busy};
    end

    int checks = 0;
    int errors = 0;
    int wr_cnt, fs_cnt, rv_cnt, exp_addr, rv_save;
    logic [2:0]  demod_or;
    logic [14:0] sb_q[$];
    logic [14:0] sb_e;
    int adc_mode;
    int adc_ph;

    // ADC source: off, continuous, or one sample every third cycle.
    always @(posedge clk) begin
        #1;
        case (adc_mode)
            1: adc_valid = 1'b1;
            2: begin
                adc_valid = (adc_ph == 0);
                adc_ph    = (adc_ph == 2) ? 0 : adc_ph + 1;
            end
            default: adc_valid = 1'b0;
        endcase
    end

    // Monitor: capture address sequence and scoreboard of reported results.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_cap_we) begin
                checks++;
                assert (o_cap_addr === 12'(exp_addr)) else begin
                    errors++;
                    $error("FAIL cap_addr observed=%0d expected=%0d", o_cap_addr, exp_addr);
                end
                exp_addr++;
                wr_cnt++;
            end
            if (o_fft_start) fs_cnt++;
            demod_or = demod_or | o_demod_en;
            if (o_res_valid) begin
                rv_cnt++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $error("FAIL res_unexpected observed=res_valid expected=none");
                end else begin
                    sb_e = sb_q.pop_front();
                    assert ({o_res_type, o_res_freq, o_res_rate, o_timeout_err} === sb_e) else begin
                        errors++;
                        $error("FAIL res_sb observed=%0h/%0h/%0h/%0b expected=%0h/%0h/%0h/%0b",
                               o_res_type, o_res_freq, o_res_rate, o_timeout_err,
                               sb_e[14:13], sb_e[12:5], sb_e[4:1], sb_e[0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fft_start(input string tag);
        int n = 0;
        while (!o_fft_start && n < 2000) begin
            tick();
            n++;
        end
        check(tag, 64'(o_fft_start), 64'd1);
    endtask

    task automatic pulse_fft(input logic [1:0] cls, input int delay);
        repeat (delay) tick();
        mod_class = cls;
        fft_done  = 1'b1;
        tick();
        fft_done  = 1'b0;
    endtask

    task automatic pulse_dem(input logic [7:0] f, input logic [3:0] r, input int delay);
        repeat (delay) tick();
        dem_freq  = f;
        dem_rate  = r;
        dem_valid = 1'b1;
        tick();
        dem_valid = 1'b0;
    endtask

    task automatic new_round();
        wr_cnt   = 0;
        fs_cnt   = 0;
        exp_addr = 0;
        demod_or = 3'b000;
    endtask

    initial begin
        sel = 1'b0; en = 1'b0; adc_valid = 1'b0; fft_done = 1'b0; dem_valid = 1'b0;
        mod_class = 2'd0; dem_freq = 8'd0; dem_rate = 4'd0;
        adc_mode = 0; adc_ph = 0; rv_cnt = 0;
        new_round();
        rst = 1'b1;
        #12;
        check("reset_outputs_n", 64'(o_all), 64'd0);
        sel = 1'b1;
        #1;
        check("reset_outputs_t", 64'(o_all), 64'd0);
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Nominal ASK round.
        adc_mode = 1;
        new_round();
        en = 1'b1;
        tick();
        check("ask_enter_capture", 64'({o_busy, o_cap_addr}), 64'({1'b1, 12'd0}));
        wait_fft_start("ask_fft_start");
        en = 1'b0;
        check("ask_writes", 64'(wr_cnt), 64'd256);
        check("ask_addr_hold", 64'(o_cap_addr), 64'd255);
        pulse_fft(CLS_ASK, 10);
        check("ask_demod_en", 64'(o_demod_en), 64'(3'b100));
        sb_q.push_back({CLS_ASK, 8'd2, 4'd4, 1'b0});
        pulse_dem(8'd2, 4'd4, 500);
        check("ask_report", 64'({o_res_valid, o_res_type, o_res_freq, o_res_rate}),
              64'({1'b1, 2'd3, 8'd2, 4'd4}));
        check("ask_fft_start_once", 64'(fs_cnt), 64'd1);
        tick();
        check("ask_idle_hold", 64'({o_busy, o_res_valid, o_res_type}), 64'({1'b0, 1'b0, 2'd3}));

        // Gapped ADC, then a no-signal classification.
        adc_mode = 2;
        new_round();
        en = 1'b1;
        tick();
        wait_fft_start("gap_fft_start");
        en = 1'b0;
        check("gap_writes", 64'(wr_cnt), 64'd256);
        tick();
        check("gap_fft_start_1cyc", 64'(o_fft_start), 64'd0);
        check("gap_addr_hold", 64'(o_cap_addr), 64'd255);
        sb_q.push_back({CLS_NONE, 8'd0, 4'd0, 1'b0});
        pulse_fft(CLS_NONE, 2);
        check("none_report_next", 64'({o_res_valid, o_res_type, o_res_freq, o_res_rate}),
              64'({1'b1, 2'd0, 8'd0, 4'd0}));
        tick();
        check("none_demod_quiet", 64'(demod_or), 64'd0);

        // Watchdog expiry with AM, fft_done coincident with fft_start.
        sel = 1'b1;
        adc_mode = 1;
        new_round();
        en = 1'b1;
        tick();
        wait_fft_start("to_fft_start");
        en = 1'b0;
        pulse_fft(CLS_AM, 0);
        check("to_demod_en", 64'(o_demod_en), 64'(3'b001));
        sb_q.push_back({CLS_AM, 8'd0, 4'd0, 1'b1});
        repeat (99) tick();
        check("to_cycle99", 64'({o_res_valid, o_demod_en}), 64'({1'b0, 3'b001}));
        tick();
        check("to_report", 64'({o_res_valid, o_timeout_err, o_res_freq}),
              64'({1'b1, 1'b1, 8'd0}));
        tick();
        check("to_sticky", 64'({o_busy, o_timeout_err}), 64'({1'b0, 1'b1}));

        // Result on the expiry cycle wins over the watchdog.
        new_round();
        en = 1'b1;
        tick();
        check("to_clear_on_start", 64'(o_timeout_err), 64'd0);
        wait_fft_start("race_fft_start");
        en = 1'b0;
        pulse_fft(CLS_AM, 2);
        sb_q.push_back({CLS_AM, 8'd7, 4'd0, 1'b0});
        pulse_dem(8'd7, 4'd6, 99);
        check("race_report", 64'({o_res_valid, o_timeout_err, o_res_freq, o_res_rate}),
              64'({1'b1, 1'b0, 8'd7, 4'd0}));
        tick();

        // Reset during FFT_WAIT drops the round.
        new_round();
        en = 1'b1;
        tick();
        wait_fft_start("rst_fft_start");
        en = 1'b0;
        tick();
        rv_save = rv_cnt;
        rst = 1'b1;
        #1;
        check("rst_async_zero", 64'(o_all), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rst_idle_after", 64'(o_busy), 64'd0);
        repeat (20) tick();
        check("rst_no_res_valid", 64'(rv_cnt), 64'(rv_save));

        // Dropping en mid-capture lets the FM round finish, then idles.
        sel = 1'b0;
        new_round();
        rv_save = rv_cnt;
        en = 1'b1;
        tick();
        repeat (10) tick();
        en = 1'b0;
        wait_fft_start("drop_fft_start");
        pulse_fft(CLS_FM, 5);
        sb_q.push_back({CLS_FM, 8'd9, 4'd0, 1'b0});
        pulse_dem(8'd9, 4'd3, 20);
        check("drop_report", 64'(o_res_valid), 64'd1);
        repeat (6) tick();
        check("drop_idle", 64'({o_busy, o_cap_we}), 64'd0);
        check("drop_one_result", 64'(rv_cnt), 64'(rv_save + 1));

        // Back-to-back FM rounds with en held high.
        new_round();
        en = 1'b1;
        tick();
        for (int rnd = 0; rnd < 2; rnd++) begin
            wait_fft_start("fm_fft_start");
            if (rnd == 1) en = 1'b0;
            pulse_fft(CLS_FM, 0);
            check("fm_demod_en", 64'(o_demod_en), 64'(3'b010));
            sb_q.push_back({CLS_FM, 8'd5, 4'd0, 1'b0});
            pulse_dem(8'd5, 4'd9, 30);
            check("fm_report", 64'({o_res_valid, o_res_type, o_res_freq, o_res_rate}),
                  64'({1'b1, 2'd2, 8'd5, 4'd0}));
            exp_addr = 0;
            tick();
            if (rnd == 0) begin
                check("fm_restart", 64'({o_busy, o_cap_we, o_cap_addr}),
                      64'({1'b1, 1'b1, 12'd0}));
            end else begin
                check("fm_final_idle", 64'(o_busy), 64'd0);
            end
        end
        adc_mode = 0;
        repeat (3) tick();
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/demod_ctrl.md
DEMOD_CTRL -- requirements
Module: demod_ctrl

Interface
REQ-001 The block SHALL use these parameters, given as name, default and meaning:
- CAP_LEN, 1024: samples captured per measurement round, power of two, 256..4096.
- TIMEOUT, 2000000: maximum clk cycles spent in DEMOD.
- AW, 12: capture address width.
REQ-002 The block SHALL have these ports, given as name, direction, width and meaning:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  run measurement rounds continuously while high.
- adc_valid  in  1  an ADC sample is present this cycle.
- cap_we  out  1  capture RAM write enable.
- cap_addr  out  AW  capture RAM write address.
- fft_start  out  1  one-cycle FFT start pulse.
- fft_done  in  1  one-cycle FFT completion pulse.
- mod_class  in  2  classifier result, sampled on fft_done: 0 none, 1 AM, 2 FM, 3 ASK.
- demod_en  out  3  one-hot demodulator enable: bit0 AM, bit1 FM, bit2 ASK.
- dem_valid  in  1  the enabled demodulator has a result.
- dem_freq  in  8  demodulated frequency in kHz.
- dem_rate  in  4  ASK bit rate in kbps.
- res_valid  out  1  one-cycle result strobe.
- res_type  out  2  measured class.
- res_freq  out  8  measured frequency in kHz.
- res_rate  out  4  measured bit rate in kbps.
- timeout_err  out  1  sticky timeout flag.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-003 The controller SHALL be an FSM with states IDLE, CAPTURE, FFT_WAIT, DEMOD and REPORT.
REQ-004 From IDLE, when en=1 the FSM SHALL move to CAPTURE on the next edge and clear cap_addr to 0.
REQ-005 In CAPTURE, cap_we SHALL equal adc_valid combinationally, and cap_addr SHALL increment after each accepted sample.
REQ-006 After sample CAP_LEN-1 is accepted, CAPTURE SHALL go to FFT_WAIT, assert fft_start for exactly the first FFT_WAIT cycle, and hold cap_addr at CAP_LEN-1 rather than wrapping it.
REQ-007 In FFT_WAIT, mod_class SHALL be latched on fft_done.
- Class 0: go to REPORT with res_freq=0 and res_rate=0.
- Any other class: go to DEMOD.
- fft_done while fft_start is high SHALL be accepted.
REQ-008 In DEMOD:
- demod_en SHALL be one-hot for the latched class; it SHALL be 0 in all other states.
- A 21-bit counter SHALL start at 0 on entry.
- dem_valid SHALL latch dem_freq and dem_rate, then go to REPORT.
- For AM and FM, res_rate SHALL be forced to 0.
REQ-009 If the DEMOD counter reaches TIMEOUT-1 without dem_valid:
- timeout_err SHALL set.
- res_freq and res_rate SHALL be set to 0.
- The FSM SHALL go to REPORT.
- dem_valid on that same cycle SHALL win, and timeout_err SHALL NOT set.
REQ-010 REPORT SHALL last one cycle with res_valid=1, then:
- go to CAPTURE if en=1;
- otherwise go to IDLE.
- res_type, res_freq and res_rate SHALL hold until the next REPORT.
REQ-011 en falling in any state other than IDLE SHALL let the current round finish. No abort SHALL occur; the FSM returns to IDLE after REPORT.
REQ-012 timeout_err SHALL clear only on reset, or on entry to CAPTURE from IDLE.
REQ-013 Latency from the last sample to res_valid SHALL be the FFT time plus demod time plus 2 cycles.

Reset
REQ-014 While rst=1, asynchronously:
- The state SHALL be IDLE.
- All outputs SHALL be 0, including cap_addr, res_type, res_freq, res_rate, timeout_err and busy.
- The timeout counter SHALL be 0.
REQ-015 Reset asserted mid-round SHALL abandon the round without issuing res_valid. The first cycle after release SHALL be IDLE.

Structure
REQ-016 A shared package, demod_pkg, SHALL hold:
- the state encoding;
- the class constants CLS_NONE, CLS_AM, CLS_FM and CLS_ASK;
- the one-hot demod_en constants.
REQ-017 The timeout counter SHALL be the single sub-module demod_timer, with ports clk, rst, clr, en and expired.

Verification
REQ-018 Nominal ASK round: CAP_LEN=256 and continuous adc_valid, with mod_class=3 on fft_done and dem_valid after 500 cycles carrying freq=8'd2 and rate=4'd4. Required response:
- cap_we is high for 256 cycles;
- fft_start is high for 1 cycle;
- demod_en=3'b100;
- res_valid fires with res_type=3, res_freq=2 and res_rate=4.
REQ-019 Gapped ADC: adc_valid 1-in-3. Required response: exactly 256 writes, addresses 0..255, no skips, and cap_addr holds at 255.
REQ-020 No signal: mod_class=0. Required response: res_valid fires 1 cycle after fft_done with res_type=0 and freq=rate=0, and demod_en is never nonzero.
REQ-021 Timeout: TIMEOUT=100 and mod_class=1 with no dem_valid. Required response: after 100 DEMOD cycles, res_valid fires with freq=0 and timeout_err=1. A second case drives dem_valid on cycle 99 and requires timeout_err=0.
REQ-022 Control and reset cases:
- Dropping en during CAPTURE: the round completes, one res_valid is issued, then IDLE.
- Asserting rst during FFT_WAIT: all outputs go to 0 immediately and no res_valid is issued.
REQ-023 FM back-to-back: mod_class=2 and dem_freq=8'd5 with en held high. Required response:
- res_rate=0;
- CAPTURE restarts at cap_addr=0 on the cycle after REPORT.
